sc1_boot_sequencer: RTL and testbench

- Boots up to N_CORES sc1_cpu cores from one shared program ROM.
- Holds every core in reset, then releases enabled cores one at a time.
- While a core is released, its rom_addr drives the shared ROM for a fixed load window. ROM data is broadcast to all cores.
- Sits between the shared ROM and the core array in multi-core tops; also exposes busy/done status for a host or reset controller.

---
 rtl/sc1_boot_sequencer.sv | 129 ++++++++++++
 tb/tb_sc1_boot_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sc1_boot_sequencer.sv
// Boots up to N_CORES cores from one shared ROM. Cores are held in reset and then released
// one at a time, each owning the ROM address bus for BOOT_CYCLES cycles.
module sc1_boot_sequencer #(
  parameter int N_CORES     = 4,
  parameter int ADDR_W      = 8,
  parameter int BOOT_CYCLES = 1032
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [N_CORES-1:0]          core_mask,
  input  logic [N_CORES*ADDR_W-1:0]   core_rom_addr,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic [N_CORES-1:0]          core_reset,
  output logic [3:0]                  active_core,
  output logic                        busy,
  output logic                        done
);

  localparam int                CNT_W     = $clog2(BOOT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [3:0]        CORE_LAST = 4'(N_CORES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SCAN  = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    count_r;
  logic [N_CORES-1:0]  mask_r;

  logic [ADDR_W-1:0]   addr_arr_s [16];
  logic [15:0]         mask_ext_s;
  logic [N_CORES-1:0]  sel_s;

  // Spread packed inputs over a full 16-entry index space so the 4-bit select indexes exactly
  always_comb begin
    mask_ext_s = 16'd0;
    sel_s      = '0;
    for (int k = 0; k < 16; k++) begin
      addr_arr_s[k] = '0;
    end
    for (int k = 0; k < N_CORES; k++) begin
      addr_arr_s[k] = core_rom_addr[k*ADDR_W +: ADDR_W];
      mask_ext_s[k] = mask_r[k];
      sel_s[k]      = (active_core == 4'(k));
    end
  end

  // The core samples ROM data two edges after driving its address, so this mux stays unregistered
  assign rom_addr = addr_arr_s[active_core];

  // Boot sequencing state machine with registered status and per-core resets
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      count_r     <= '0;
      mask_r      <= '0;
      core_reset  <= '1;
      active_core <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mask_r      <= core_mask;
            active_core <= 4'd0;
            busy        <= 1'b1;
            state_r     <= SCAN;
          end else begin
            busy <= 1'b0;
            done <= 1'b0;
          end
        end
        CLEAR: begin
          active_core <= 4'd0;
          state_r     <= SCAN;
        end
        SCAN: begin
          if (mask_ext_s[active_core]) begin
            core_reset <= core_reset & ~sel_s;
            count_r    <= '0;
            state_r    <= LOAD;
          end else if (active_core == CORE_LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            active_core <= active_core + 4'd1;
          end
        end
        LOAD: begin
          count_r <= count_r + CNT_W'(1);
          if (count_r == CNT_LAST) begin
            if (active_core == CORE_LAST) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              active_core <= active_core + 4'd1;
              state_r     <= SCAN;
            end
          end
        end
        DONE: begin
          // Re-boot passes through CLEAR so every core sees a full reset cycle
          if (start) begin
            mask_r     <= core_mask;
            core_reset <= '1;
            done       <= 1'b0;
            busy       <= 1'b1;
            state_r    <= CLEAR;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc1_boot_sequencer.sv
// Self-checking bench: a schedule-based model of the boot timeline is compared with the DUT every cycle.
module tb_sc1_boot_sequencer;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int BC = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [N-1:0]      core_mask;
  logic [N*AW-1:0]   cra;
  logic [AW-1:0]     rom_addr;
  logic [N-1:0]      core_reset;
  logic [3:0]        active_core;
  logic              busy;
  logic              done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit checking  = 1'b0;

  sc1_boot_sequencer #(.N_CORES(N), .ADDR_W(AW), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .start(start), .core_mask(core_mask),
    .core_rom_addr(cra), .rom_addr(rom_addr), .core_reset(core_reset),
    .active_core(active_core), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: on an accepted start, lay out when each core's scan slot begins and when done arrives
  bit          idle_m = 1'b1;
  bit          clear_m;
  int          e_m;
  logic [N-1:0] mask_m;
  int          scan_at [N];
  int          done_e;

  always @(posedge clk) begin
    if (reset) begin
      idle_m = 1'b1;
    end else if (start && (idle_m || e_m >= done_e)) begin
      int pos;
      clear_m = !idle_m;
      idle_m  = 1'b0;
      mask_m  = core_mask;
      e_m     = 0;
      pos     = clear_m ? 1 : 0;
      for (int k = 0; k < N; k++) begin
        scan_at[k] = pos;
        pos += mask_m[k] ? BC + 1 : 1;
      end
      done_e = pos;
    end else if (!idle_m) begin
      e_m++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic [N-1:0] exp_cr;
      int           exp_ac;
      logic         exp_busy, exp_done;
      if (idle_m) begin
        exp_cr = '1; exp_ac = 0; exp_busy = 1'b0; exp_done = 1'b0;
      end else if (e_m >= done_e) begin
        exp_cr = ~mask_m; exp_ac = N - 1; exp_busy = 1'b0; exp_done = 1'b1;
      end else if (clear_m && e_m == 0) begin
        exp_cr = '1; exp_ac = N - 1; exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        exp_busy = 1'b1; exp_done = 1'b0; exp_ac = 0;
        for (int k = 0; k < N; k++) begin
          if (scan_at[k] <= e_m) exp_ac = k;
          exp_cr[k] = !(mask_m[k] && e_m >= scan_at[k] + 1);
        end
      end
      check("model_core_reset", 32'(core_reset), 32'(exp_cr));
      check("model_active_core", 32'(active_core), 32'(exp_ac));
      check("model_busy", 32'(busy), 32'(exp_busy));
      check("model_done", 32'(done), 32'(exp_done));
      check("model_rom_addr", 32'(rom_addr), 32'(cra[exp_ac*AW +: AW]));
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; core_mask = '0;
    cra = {8'h13, 8'h12, 8'h11, 8'h10};
    step(2);
    reset = 1'b0; checking = 1'b1;
    check("rst_core_reset", 32'(core_reset), 32'h0000000F);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_active", 32'(active_core), 32'd0);

    // full mask; a start during LOAD of core 1 must be ignored
    core_mask = 4'hF; start = 1'b1; step(1); start = 1'b0;
    check("full_busy", 32'(busy), 32'd1);
    check("full_model_done_e", 32'(done_e), 32'd36);
    step(1);
    check("full_cr_e1", 32'(core_reset), 32'h0000000E);
    check("full_addr_e1", 32'(rom_addr), 32'h00000010);
    step(8);
    check("full_active_e9", 32'(active_core), 32'd1);
    check("full_addr_e9", 32'(rom_addr), 32'h00000011);
    check("full_cr_e9", 32'(core_reset), 32'h0000000E);
    step(1);
    check("full_cr_e10", 32'(core_reset), 32'h0000000C);
    start = 1'b1; core_mask = 4'h0; step(1); start = 1'b0; core_mask = 4'hF;
    step(24);
    check("full_done_e35", 32'(done), 32'd0);
    step(1);
    check("full_done_e36", 32'(done), 32'd1);
    check("full_cr_e36", 32'(core_reset), 32'h00000000);

    // re-boot from DONE with mask 1010
    core_mask = 4'hA; start = 1'b1; step(1); start = 1'b0;
    check("reboot_clear_cr", 32'(core_reset), 32'h0000000F);
    check("reboot_clear_done", 32'(done), 32'd0);
    step(20);
    check("mask_a_done_early", 32'(done), 32'd0);
    step(1);
    check("mask_a_done", 32'(done), 32'd1);
    check("mask_a_cr", 32'(core_reset), 32'h00000005);

    // all-zero mask from IDLE
    reset = 1'b1; step(1); reset = 1'b0;
    core_mask = 4'h0; start = 1'b1; step(1); start = 1'b0;
    step(3);
    check("zero_done_e3", 32'(done), 32'd0);
    step(1);
    check("zero_done_e4", 32'(done), 32'd1);
    check("zero_cr", 32'(core_reset), 32'h0000000F);

    // reset during LOAD of core 2
    core_mask = 4'hF; start = 1'b1; step(1); start = 1'b0;
    step(23);
    check("midload_cr", 32'(core_reset), 32'h00000008);
    check("midload_active", 32'(active_core), 32'd2);
    reset = 1'b1; step(1); reset = 1'b0;
    check("midrst_cr", 32'(core_reset), 32'h0000000F);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_active", 32'(active_core), 32'd0);
    step(5);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_idle_cr", 32'(core_reset), 32'h0000000F);

    // randomized traffic against the model
    repeat (3000) begin
      cra       = $urandom;
      core_mask = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 599) == 0);
      step(1);
    end
    start = 1'b0; reset = 1'b0;
    step(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
